// File: rtl/ocp_pkg.sv
// Shared OCP encodings and the burst master state type.
package ocp_pkg;

    // Request-phase command encodings
    localparam logic [2:0] MCMD_IDLE = 3'b000;
    localparam logic [2:0] MCMD_WR   = 3'b001;
    localparam logic [2:0] MCMD_RD   = 3'b010;

    // Response-phase encodings
    localparam logic [1:0] SRESP_NULL = 2'b00;
    localparam logic [1:0] SRESP_DVA  = 2'b01;
    localparam logic [1:0] SRESP_FAIL = 2'b10;
    localparam logic [1:0] SRESP_ERR  = 2'b11;

    localparam logic [2:0] BURST_INCR = 3'b000;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StRsp
    } state_e;

endpackage

// File: rtl/ocp_burst_master.sv
// OCP master sequencer: turns host burst descriptors and a write-data stream into
// per-beat INCR requests, and forwards read responses onto a host valid/ready stream.
module ocp_burst_master
    import ocp_pkg::*;
#(
    parameter int unsigned TAGI_WIDTH = 5,
    parameter int unsigned BLEN_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [2:0]              cmd_op,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [BLEN_WIDTH-1:0]   cmd_len,
    input  logic [DATA_WIDTH/8-1:0] cmd_byteen,
    output logic                    cmd_err,
    input  logic                    wdata_valid,
    output logic                    wdata_ready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [2:0]              mcmd,
    output logic [ADDR_WIDTH-1:0]   maddr,
    output logic [BLEN_WIDTH-1:0]   mburstlenght,
    output logic [2:0]              mburstseq,
    output logic [DATA_WIDTH/8-1:0] mbyteen,
    output logic [DATA_WIDTH-1:0]   mdata,
    input  logic                    scmdaccept,
    input  logic [1:0]              sresp,
    input  logic [DATA_WIDTH-1:0]   sdata,
    output logic                    mrespaccept,
    output logic                    rdata_valid,
    input  logic                    rdata_ready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    rdata_last,
    output logic                    rsp_err
);

    localparam int unsigned BeWidth = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] AddrStep = ADDR_WIDTH'(BeWidth);

    // Tag width is reserved for a tagged extension and has no logic yet
    logic [TAGI_WIDTH-1:0] unused_tag;
    assign unused_tag = '0;

    state_e                  state_q, state_d;
    logic [2:0]              mcmd_q, mcmd_d;
    logic [ADDR_WIDTH-1:0]   maddr_q, maddr_d;
    logic [BLEN_WIDTH-1:0]   len_q, len_d;
    logic [BeWidth-1:0]      byteen_q, byteen_d;
    logic [DATA_WIDTH-1:0]   mdata_q, mdata_d;
    logic [BLEN_WIDTH-1:0]   req_cnt_q, req_cnt_d;
    logic [BLEN_WIDTH-1:0]   rsp_cnt_q, rsp_cnt_d;

    logic cmd_ok, cmd_take, in_read, rsp_take, req_accept, wdata_take;

    // Handshake decode and the combinational read-return passthrough
    always_comb begin
        cmd_ok      = ((cmd_op == MCMD_WR) || (cmd_op == MCMD_RD)) && (cmd_len != '0);
        cmd_ready   = (state_q == StIdle) && !rst;
        cmd_take    = cmd_ready && cmd_valid && cmd_ok;
        cmd_err     = cmd_ready && cmd_valid && !cmd_ok;
        in_read     = (state_q == StRd) || (state_q == StRsp);
        rdata_valid = in_read && (sresp != SRESP_NULL);
        mrespaccept = in_read && rdata_ready;
        rsp_take    = rdata_valid && rdata_ready;
        rsp_err     = rsp_take && ((sresp == SRESP_FAIL) || (sresp == SRESP_ERR));
        rdata       = sdata;
        rdata_last  = rdata_valid && (rsp_cnt_q == len_q - BLEN_WIDTH'(1));
        req_accept  = (mcmd_q != MCMD_IDLE) && scmdaccept;
        // A new write beat may load into the slot the slave is accepting this cycle
        wdata_ready = (state_q == StWr) && (req_cnt_q != len_q)
                      && ((mcmd_q != MCMD_WR) || scmdaccept);
        wdata_take  = wdata_ready && wdata_valid;
    end

    // Next-state and registered request fields
    always_comb begin
        state_d   = state_q;
        mcmd_d    = mcmd_q;
        maddr_d   = maddr_q;
        len_d     = len_q;
        byteen_d  = byteen_q;
        mdata_d   = mdata_q;
        req_cnt_d = req_cnt_q;
        rsp_cnt_d = rsp_take ? rsp_cnt_q + BLEN_WIDTH'(1) : rsp_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_take) begin
                    len_d     = cmd_len;
                    byteen_d  = cmd_byteen;
                    maddr_d   = cmd_addr;
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                    if (cmd_op == MCMD_WR) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRd;
                        mcmd_d  = MCMD_RD;
                    end
                end
            end
            StWr: begin
                // req_cnt counts beats loaded from the wdata stream
                if (req_accept) begin
                    maddr_d = maddr_q + AddrStep;
                    mcmd_d  = MCMD_IDLE;
                end
                if (wdata_take) begin
                    mcmd_d    = MCMD_WR;
                    mdata_d   = wdata;
                    req_cnt_d = req_cnt_q + BLEN_WIDTH'(1);
                end else if (req_accept && (req_cnt_q == len_q)) begin
                    state_d = StIdle;
                end
            end
            StRd: begin
                // req_cnt counts read requests accepted by the slave
                if (req_accept) begin
                    maddr_d   = maddr_q + AddrStep;
                    req_cnt_d = req_cnt_q + BLEN_WIDTH'(1);
                    if (req_cnt_q == len_q - BLEN_WIDTH'(1)) begin
                        mcmd_d  = MCMD_IDLE;
                        state_d = (rsp_cnt_d == len_q) ? StIdle : StRsp;
                    end
                end
            end
            StRsp: begin
                if (rsp_cnt_d == len_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and request registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            mcmd_q    <= MCMD_IDLE;
            maddr_q   <= '0;
            len_q     <= '0;
            byteen_q  <= '0;
            mdata_q   <= '0;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mcmd_q    <= mcmd_d;
            maddr_q   <= maddr_d;
            len_q     <= len_d;
            byteen_q  <= byteen_d;
            mdata_q   <= mdata_d;
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

    assign mcmd         = mcmd_q;
    assign maddr        = maddr_q;
    assign mburstlenght = len_q;
    assign mburstseq    = BURST_INCR;
    assign mbyteen      = byteen_q;
    assign mdata        = mdata_q;

endmodule
